mux_rr_nto1: RTL and testbench

//  Parametrised N:1 channel multiplexer; successor to the combinational 2:1 mux.

---
 rtl/mux_rr_nto1.sv | 163 ++++++++++++++++
 tb/tb_mux_rr_nto1.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N:1 valid/ready channel mux with a registered output stage.
// Channel choice is round-robin (mode=0) or fixed by S (mode=1).
// Optional macro MUX_PKT_LOCK_EN adds in_last and holds the grant on one
// channel until that channel's last beat is accepted.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_data        N packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid       per-channel word present
//   in_last        per-channel last beat (only with MUX_PKT_LOCK_EN)
//   in_ready       per-channel accept strobe, one-hot or zero
//   mode, S        0 = round-robin, 1 = fixed channel S
//   out_data       registered selected word
//   out_valid      out_data holds a word
//   out_ready      downstream accepts out_data
//   out_sel        index of the channel that supplied out_data
module mux_rr_nto1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
`ifdef MUX_PKT_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   S,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  localparam logic [SEL_W:0] LP_N =
    (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LP_LAST =
    SEL_W'(N-1);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_ptr;

`ifdef MUX_PKT_LOCK_EN
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_ch;
`endif

  logic             w_load;
  logic [SEL_W:0]   w_scan;
  logic             w_rr_hit;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_fx_hit;
  logic             w_gnt;
  logic [SEL_W-1:0] w_gidx;
  logic [SEL_W-1:0] w_nxt_ptr;
  logic [WIDTH-1:0] w_gdata;

  // rst gates load so no in_ready is issued while reset is held.
  assign w_load = !rst && (!r_out_valid || out_ready);

  // Scan ptr, ptr+1, ... with the sum kept one bit wider so the
  // modulo-N wrap is a single conditional subtract.
  always_comb begin
    w_scan   = '0;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_scan = {1'b0, r_ptr} + (SEL_W+1)'(k);
      if (w_scan >= LP_N) begin
        w_scan = w_scan - LP_N;
      end
      if (!w_rr_hit && in_valid[w_scan[SEL_W-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_scan[SEL_W-1:0];
      end
    end
  end

  // An out-of-range S grants nothing.
  always_comb begin
    w_fx_hit = 1'b0;
    if ({1'b0, S} < LP_N) begin
      w_fx_hit = in_valid[S];
    end
  end

  always_comb begin
    w_gnt  = 1'b0;
    w_gidx = '0;
`ifdef MUX_PKT_LOCK_EN
    if (r_lock) begin
      w_gnt  = in_valid[r_lock_ch];
      w_gidx = r_lock_ch;
    end else if (mode) begin
      w_gnt  = w_fx_hit;
      w_gidx = S;
    end else begin
      w_gnt  = w_rr_hit;
      w_gidx = w_rr_idx;
    end
`else
    if (mode) begin
      w_gnt  = w_fx_hit;
      w_gidx = S;
    end else begin
      w_gnt  = w_rr_hit;
      w_gidx = w_rr_idx;
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (w_load && w_gnt) begin
      in_ready[w_gidx] = 1'b1;
    end
  end

  assign w_nxt_ptr = (w_gidx == LP_LAST) ?
                     '0 : w_gidx + 1'b1;

  assign w_gdata = in_data[int'(w_gidx)*WIDTH +: WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
`ifdef MUX_PKT_LOCK_EN
      r_lock      <= 1'b0;
      r_lock_ch   <= '0;
`endif
    end else if (w_load) begin
      if (w_gnt) begin
        r_out_data  <= w_gdata;
        r_out_sel   <= w_gidx;
        r_out_valid <= 1'b1;
`ifdef MUX_PKT_LOCK_EN
        // Pointer moves only when a packet completes.
        r_lock    <= !in_last[w_gidx];
        r_lock_ch <= w_gidx;
        if (in_last[w_gidx]) begin
          r_ptr <= w_nxt_ptr;
        end
`else
        r_ptr <= w_nxt_ptr;
`endif
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: scoreboard bench for mux_rr_nto1.
// Directed scenarios followed by random traffic against a reference model.
module tb_mux_rr_nto1;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = $clog2(N);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
`ifdef MUX_PKT_LOCK_EN
  logic [N-1:0]       in_last = '1;
`endif
  logic [N-1:0]       in_ready;
  logic               mode = 1'b0;
  logic [SEL_W-1:0]   S = '0;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [SEL_W-1:0]   out_sel;

  always #5 clk = ~clk;

  mux_rr_nto1 #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef MUX_PKT_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .mode      (mode),
    .S         (S),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit m_valid = 1'b0;
  int m_ptr   = 0;
  bit m_lock  = 1'b0;
  int m_lk    = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int mgrant(logic [N-1:0] v,
                                bit md, int s);
    if (m_lock) return v[m_lk] ? m_lk : -1;
    if (md) begin
      if (s < N) return v[s] ? s : -1;
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic cyc(logic [N-1:0] v, bit md, int s,
                     bit rdy, logic [N-1:0] lst);
    bit             ld;
    int             g;
    logic [N-1:0]   er;
    logic [WIDTH-1:0] d;
    exp_t           e;
    @(negedge clk);
    in_valid  = v;
    mode      = md;
    S         = SEL_W'(s);
    out_ready = rdy;
`ifdef MUX_PKT_LOCK_EN
    in_last   = lst;
`endif
    for (int i = 0; i < N; i++)
      in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    #1;
    ld = !m_valid || rdy;
    g  = ld ? mgrant(v, md, s) : -1;
    er = '0;
    d  = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      d = in_data[g*WIDTH +: WIDTH];
    end
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    if (ld) begin
      if (g >= 0) begin
        e.sel  = SEL_W'(g);
        e.data = d;
        q.push_back(e);
        m_valid = 1'b1;
`ifdef MUX_PKT_LOCK_EN
        if (lst[g]) begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock = 1'b1;
          m_lk   = g;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    in_valid  = '1;
    out_ready = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'(m_valid));
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    q.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_lock  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_ready", 32'(in_ready), 32'd0);
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
  endtask

  // Monitor: checks the presented word against the scoreboard head
  // and retires it when the downstream accepts it.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        chk("out_valid", 32'(out_valid),
            32'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
          chk("out_sel", 32'(out_sel), 32'(q[0].sel));
          chk("out_data", 32'(out_data), 32'(q[0].data));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  localparam logic [N-1:0] ALL = '1;
  localparam logic [N-1:0] NONE = '0;

  initial begin
    #7;
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_data", 32'(out_data), 32'd0);
    chk("init_sel", 32'(out_sel), 32'd0);
    chk("init_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Round-robin fairness, full throughput
    repeat (8) cyc(ALL, 1'b0, 0, 1'b1, ALL);
    // Backpressure then release
    repeat (3) cyc(ALL, 1'b0, 0, 1'b0, ALL);
    repeat (2) cyc(ALL, 1'b0, 0, 1'b1, ALL);
    // Fixed select, then selected channel goes idle
    repeat (4) cyc(ALL, 1'b1, 2, 1'b1, ALL);
    repeat (2) cyc(4'b1011, 1'b1, 2, 1'b1, ALL);
    // Skip and wrap: ptr=3 after ch2 grant
    cyc(ALL, 1'b1, 2, 1'b1, ALL);
    cyc(4'b0010, 1'b0, 0, 1'b1, ALL);
    cyc(4'b0001, 1'b0, 0, 1'b1, ALL);
    // Reset while a word is held
    cyc(ALL, 1'b0, 0, 1'b1, ALL);
    cyc(ALL, 1'b0, 0, 1'b0, ALL);
    mid_reset();
    repeat (3) cyc(ALL, 1'b0, 0, 1'b1, ALL);
`ifdef MUX_PKT_LOCK_EN
    // Three-beat packet on ch1 while ch0/ch2 wait
    cyc(4'b0111, 1'b1, 1, 1'b1, NONE);
    cyc(4'b0111, 1'b0, 0, 1'b1, NONE);
    cyc(4'b0111, 1'b0, 0, 1'b1, 4'b0010);
    cyc(4'b0111, 1'b0, 0, 1'b1, ALL);
`endif
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(N'($urandom),
          ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, (1 << SEL_W) - 1)),
          ($urandom_range(0, 3) != 0),
          N'($urandom));
      if (i == 1500) begin
        cyc(ALL, 1'b0, 0, 1'b0, ALL);
        mid_reset();
      end
    end
    repeat (4) cyc(NONE, 1'b0, 0, 1'b1, ALL);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
